// File: rtl/sample_rate_monitor.sv
// Sample clock rate monitor: measures sample_clk periods in clk_in cycles and
// tracks lock to the nominal rate with hysteresis on good/bad period runs.
module sample_rate_monitor #(
    parameter int NOMINAL    = 128,
    parameter int TOL        = 2,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       sample_clk,
    output logic       sample_stb,
    output logic [8:0] period,
    output logic       locked,
    output logic       err_stb
);

    // state  | meaning
    // SEARCH | no lock, waiting for a first good period
    // ACQ    | counting consecutive good periods towards lock
    // LOCKED | rate within tolerance
    // FAULT  | still locked, counting consecutive bad periods towards unlock
    typedef enum logic [1:0] {S_SEARCH, S_ACQ, S_LOCKED, S_FAULT} state_t;

    localparam logic [9:0] NOM_W    = 10'(NOMINAL);
    localparam logic [9:0] TOL_W    = 10'(TOL);
    localparam logic [7:0] LOCK_W   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_W = 8'(UNLOCK_CNT);

    logic       sync1_q, sync2_q, sync3_q;
    logic [8:0] cnt_q, cnt_d;
    logic       seen_q, seen_d;
    state_t     state_q, state_d;
    logic [7:0] good_cnt_q, good_cnt_d;
    logic [7:0] bad_cnt_q, bad_cnt_d;
    logic       sample_stb_q;
    logic [8:0] period_q, period_d;
    logic       locked_q, locked_d;
    logic       err_stb_q, err_stb_d;

    logic       rise, timeout, eval, good;
    logic [8:0] meas;
    logic [9:0] diff;

    assign rise    = sync2_q & ~sync3_q;
    assign timeout = ~rise & (cnt_q == 9'd510);
    assign meas    = (cnt_q == 9'd511) ? 9'd511 : cnt_q + 9'd1;
    assign eval    = rise & seen_q;
    assign diff    = ({1'b0, meas} >= NOM_W) ? {1'b0, meas} - NOM_W : NOM_W - {1'b0, meas};
    assign good    = (diff <= TOL_W);

    always_comb begin
        cnt_d  = cnt_q;
        seen_d = seen_q;
        if (rise) begin
            cnt_d  = 9'd0;
            seen_d = 1'b1;
        end else begin
            if (cnt_q != 9'd511) cnt_d = cnt_q + 9'd1;
            if (timeout) seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_SEARCH;
            good_cnt_q <= 8'd0;
            bad_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    // A timeout never coincides with an evaluation: timeout requires no rise.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (timeout) begin
            state_d    = S_SEARCH;
            good_cnt_d = 8'd0;
            bad_cnt_d  = 8'd0;
        end else if (eval) begin
            case (state_q)
                S_SEARCH: begin
                    if (good) begin
                        if (LOCK_W <= 8'd1) begin
                            state_d    = S_LOCKED;
                            good_cnt_d = 8'd0;
                        end else begin
                            state_d    = S_ACQ;
                            good_cnt_d = 8'd1;
                        end
                    end
                end
                S_ACQ: begin
                    if (!good) begin
                        state_d    = S_SEARCH;
                        good_cnt_d = 8'd0;
                    end else if (good_cnt_q + 8'd1 >= LOCK_W) begin
                        state_d    = S_LOCKED;
                        good_cnt_d = 8'd0;
                    end else begin
                        good_cnt_d = good_cnt_q + 8'd1;
                    end
                end
                S_LOCKED: begin
                    if (!good) begin
                        if (UNLOCK_W <= 8'd1) begin
                            state_d   = S_SEARCH;
                            bad_cnt_d = 8'd0;
                        end else begin
                            state_d   = S_FAULT;
                            bad_cnt_d = 8'd1;
                        end
                    end
                end
                S_FAULT: begin
                    if (good) begin
                        state_d   = S_LOCKED;
                        bad_cnt_d = 8'd0;
                    end else if (bad_cnt_q + 8'd1 >= UNLOCK_W) begin
                        state_d   = S_SEARCH;
                        bad_cnt_d = 8'd0;
                    end else begin
                        bad_cnt_d = bad_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d    = S_SEARCH;
                    good_cnt_d = 8'd0;
                    bad_cnt_d  = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        locked_d  = (state_d == S_LOCKED) || (state_d == S_FAULT);
        err_stb_d = timeout | (eval & ~good);
        period_d  = eval ? meas : period_q;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            cnt_q        <= 9'd0;
            seen_q       <= 1'b0;
            sample_stb_q <= 1'b0;
            period_q     <= 9'd0;
            locked_q     <= 1'b0;
            err_stb_q    <= 1'b0;
        end else begin
            sync1_q      <= sample_clk;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            cnt_q        <= cnt_d;
            seen_q       <= seen_d;
            sample_stb_q <= rise;
            period_q     <= period_d;
            locked_q     <= locked_d;
            err_stb_q    <= err_stb_d;
        end
    end

    assign sample_stb = sample_stb_q;
    assign period     = period_q;
    assign locked     = locked_q;
    assign err_stb    = err_stb_q;

endmodule

// File: doc/sample_rate_monitor.md
SAMPLE_RATE_MONITOR -- requirements
Module: sample_rate_monitor

Interface
REQ-001 The block SHALL have parameter NOMINAL, default 128, giving the expected clk_in cycles per sample_clk period (5.6448 MHz / 44.1 kHz).
REQ-002 The block SHALL have parameter TOL, default 2, giving the allowed +/- deviation in cycles for a good period.
REQ-003 The block SHALL have parameter LOCK_CNT, default 4, giving the consecutive good periods required to assert lock.
REQ-004 The block SHALL have parameter UNLOCK_CNT, default 2, giving the consecutive bad periods required to drop lock.
REQ-005 The block SHALL have port clk_in, input, 1 bit: the single clock, 128x44.1 kHz; all logic is on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port sample_clk, input, 1 bit: incoming frame/sample clock, asynchronous to clk_in.
REQ-008 The block SHALL have port sample_stb, output, 1 bit: one-cycle pulse per detected sample_clk rising edge.
REQ-009 The block SHALL have port period, output, 9 bits: last valid measured period in clk_in cycles.
REQ-010 The block SHALL have port locked, output, 1 bit: sample rate within tolerance and stable.
REQ-011 The block SHALL have port err_stb, output, 1 bit: one-cycle pulse per bad period or timeout.

Function
REQ-012 sample_clk SHALL pass through a 2-flop synchronizer followed by a third delay flop; rise = sync2 & ~sync3.
REQ-013 sample_stb SHALL be registered from rise: it goes high exactly one cycle, 3 clk_in edges after sample_clk is first sampled high.
REQ-014 A 9-bit counter cnt SHALL clear to 0 in a rise cycle, otherwise increment, saturating at 511.
REQ-015 On a rise, the measurement SHALL be cnt+1, saturated at 511; rises exactly 128 cycles apart give 128.
REQ-016 The first rise after reset or after a timeout SHALL only arm the measurement (set the seen flag); it SHALL NOT be evaluated and SHALL NOT update period.
REQ-017 Each armed measurement SHALL update period and be classed good when |meas - NOMINAL| <= TOL, bad otherwise.
REQ-018 The FSM SHALL have states SEARCH, ACQ, LOCKED, FAULT; locked=1 only in LOCKED and FAULT.
REQ-019 SEARCH: a good measurement moves to ACQ with good_cnt=1; a bad one stays in SEARCH.
REQ-020 ACQ: a good measurement increments good_cnt and moves to LOCKED on reaching LOCK_CNT; a bad one moves to SEARCH and clears good_cnt.
REQ-021 LOCKED: a bad measurement moves to FAULT with bad_cnt=1 (or straight to SEARCH if UNLOCK_CNT=1); a good one stays.
REQ-022 FAULT: a good measurement returns to LOCKED and clears bad_cnt; a bad one increments bad_cnt and moves to SEARCH on reaching UNLOCK_CNT.
REQ-023 Timeout SHALL fire in the cycle cnt steps 510->511 without a rise: FSM to SEARCH, seen cleared, counters cleared, err_stb pulsed once; cnt holds 511 with no further pulses.
REQ-024 When a rise coincides with the timeout cycle, the rise SHALL take priority: measurement 511 (bad), and no separate timeout.
REQ-025 err_stb SHALL pulse one cycle, registered with the FSM update, for every bad armed measurement in any state.
REQ-026 locked and the FSM SHALL update in the cycle after the rise cycle, the same cycle as sample_stb and period.

Reset
REQ-027 While reset_n=0, all flops SHALL clear asynchronously: sync chain 0, cnt 0, seen 0, FSM SEARCH, counters 0, sample_stb 0, period 0, locked 0, err_stb 0.
REQ-028 Reset deassertion mid-frame SHALL restart acquisition; the first rise afterwards is arm-only.

Verification
REQ-029 Periodic sample_clk, 128-cycle period, 50% duty -> sample_stb one cycle per period; period=128 from the 2nd rise; locked=1 after the 5th rise; err_stb never asserts.
REQ-030 Locked, then one period of 140 -> err_stb one pulse, FSM FAULT, locked stays 1; next period 128 -> LOCKED.
REQ-031 Locked, then two consecutive periods of 100 -> two err_stb pulses; locked=0 after the second; period=100.
REQ-032 Locked, then sample_clk held low -> exactly one err_stb when cnt reaches 511, locked=0; on restart, the first rise is arm-only and relock takes 5 rises.
REQ-033 Boundary periods 126 and 130 -> good; 125 and 131 -> bad, with period showing the exact value.
REQ-034 Assert reset_n=0 while LOCKED mid-period -> all outputs 0 immediately; after release, behaviour matches the REQ-029 sequence.
